// File: rtl/custom_mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single shared memory port.
// One transaction outstanding at a time; stall_cnt accumulates cycles a requester waited unserved.
module custom_mem_arbiter #(
    parameter logic DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic        bus_ren,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_req_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rdata_valid,
    output logic        bus_rdata_ack,
    output logic [31:0] stall_cnt
);

    typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, RESP_I, RESP_D} state_t;
    typedef enum logic [1:0] {KIND_I, KIND_DR, KIND_DW} kind_t;

    state_t      state_r;
    kind_t       kind_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  strb_r;
    logic        last_data_r;
    logic [31:0] stall_cnt_r;

    logic        inst_pend_s;
    logic        data_pend_s;
    logic        grant_i_s;
    logic        grant_d_s;

    assign inst_pend_s = Inst_Req_Valid;
    assign data_pend_s = MemRead | MemWrite;

    // Arbitration: grants only happen in IDLE; ties go to data or alternate by last grant
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == IDLE) begin
            if (inst_pend_s && data_pend_s) begin
                if ((DATA_FIRST != 1'b0) || !last_data_r) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b1;
                end
            end else if (data_pend_s) begin
                grant_d_s = 1'b1;
            end else if (inst_pend_s) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Transaction FSM and request latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            kind_r      <= KIND_I;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            strb_r      <= 4'b0000;
            last_data_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r     <= REQ_D;
                        kind_r      <= MemWrite ? KIND_DW : KIND_DR;
                        addr_r      <= Address;
                        wdata_r     <= MemWrite ? Write_data : 32'h0000_0000;
                        strb_r      <= Write_strb;
                        last_data_r <= 1'b1;
                    end else if (grant_i_s) begin
                        state_r     <= REQ_I;
                        kind_r      <= KIND_I;
                        addr_r      <= PC;
                        wdata_r     <= 32'h0000_0000;
                        strb_r      <= 4'b1111;
                        last_data_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ_I: begin
                    state_r <= bus_req_ack ? RESP_I : REQ_I;
                end
                REQ_D: begin
                    if (bus_req_ack) begin
                        // writes complete on the request handshake alone
                        state_r <= (kind_r == KIND_DW) ? IDLE : RESP_D;
                    end else begin
                        state_r <= REQ_D;
                    end
                end
                RESP_I: begin
                    state_r <= (bus_rdata_valid && Inst_Ack) ? IDLE : RESP_I;
                end
                RESP_D: begin
                    state_r <= (bus_rdata_valid && Read_data_Ack) ? IDLE : RESP_D;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Stall counter: a pending request that received no ack this cycle, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if ((inst_pend_s || data_pend_s) && !grant_i_s && !grant_d_s
                     && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Output decode: each state owns its slice of the bus/CPU outputs, all else is zero
    always_comb begin
        bus_addr        = 32'h0000_0000;
        bus_wdata       = 32'h0000_0000;
        bus_strb        = 4'b0000;
        bus_ren         = 1'b0;
        bus_wen         = 1'b0;
        bus_rdata_ack   = 1'b0;
        Instruction     = 32'h0000_0000;
        Inst_Valid      = 1'b0;
        Read_data       = 32'h0000_0000;
        Read_data_Valid = 1'b0;
        case (state_r)
            REQ_I: begin
                bus_addr  = addr_r;
                bus_wdata = wdata_r;
                bus_strb  = strb_r;
                bus_ren   = 1'b1;
            end
            REQ_D: begin
                bus_addr  = addr_r;
                bus_wdata = wdata_r;
                bus_strb  = strb_r;
                bus_ren   = (kind_r == KIND_DR);
                bus_wen   = (kind_r == KIND_DW);
            end
            RESP_I: begin
                Instruction   = bus_rdata;
                Inst_Valid    = bus_rdata_valid;
                bus_rdata_ack = Inst_Ack;
            end
            RESP_D: begin
                Read_data       = bus_rdata;
                Read_data_Valid = bus_rdata_valid;
                bus_rdata_ack   = Read_data_Ack;
            end
            default: begin
                bus_addr = 32'h0000_0000;
            end
        endcase
    end

    assign Inst_Req_Ack = grant_i_s;
    assign Mem_Req_Ack  = grant_d_s;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_custom_mem_arbiter.sv
// Directed bench for custom_mem_arbiter: a data-first instance plus a round-robin instance
// sharing the same stimulus; expected values are hand-derived per cycle.
module tb_custom_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, Address, Write_data, bus_rdata;
    logic        Inst_Req_Valid, Inst_Ack, MemWrite, MemRead, Read_data_Ack;
    logic [3:0]  Write_strb;
    logic        bus_req_ack, bus_rdata_valid;

    logic        Inst_Req_Ack, Inst_Valid, Mem_Req_Ack, Read_data_Valid;
    logic        bus_wen, bus_ren, bus_rdata_ack;
    logic [31:0] Instruction, Read_data, bus_addr, bus_wdata, stall_cnt;
    logic [3:0]  bus_strb;

    logic        inst_req_ack_rr, inst_valid_rr, mem_req_ack_rr, read_data_valid_rr;
    logic        bus_wen_rr, bus_ren_rr, bus_rdata_ack_rr;
    logic [31:0] instruction_rr, read_data_rr, bus_addr_rr, bus_wdata_rr, stall_cnt_rr;
    logic [3:0]  bus_strb_rr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    custom_mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
        .Inst_Req_Ack(Inst_Req_Ack), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
        .Inst_Ack(Inst_Ack), .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_wdata(bus_wdata),
        .bus_strb(bus_strb), .bus_req_ack(bus_req_ack), .bus_rdata(bus_rdata),
        .bus_rdata_valid(bus_rdata_valid), .bus_rdata_ack(bus_rdata_ack), .stall_cnt(stall_cnt)
    );

    custom_mem_arbiter #(.DATA_FIRST(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
        .Inst_Req_Ack(inst_req_ack_rr), .Instruction(instruction_rr), .Inst_Valid(inst_valid_rr),
        .Inst_Ack(Inst_Ack), .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(mem_req_ack_rr),
        .Read_data(read_data_rr), .Read_data_Valid(read_data_valid_rr), .Read_data_Ack(Read_data_Ack),
        .bus_addr(bus_addr_rr), .bus_wen(bus_wen_rr), .bus_ren(bus_ren_rr), .bus_wdata(bus_wdata_rr),
        .bus_strb(bus_strb_rr), .bus_req_ack(bus_req_ack), .bus_rdata(bus_rdata),
        .bus_rdata_valid(bus_rdata_valid), .bus_rdata_ack(bus_rdata_ack_rr), .stall_cnt(stall_cnt_rr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; PC = 32'h0; Address = 32'h0; Write_data = 32'h0; bus_rdata = 32'h0;
        Inst_Req_Valid = 1'b0; Inst_Ack = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        Read_data_Ack = 1'b0; Write_strb = 4'b0000; bus_req_ack = 1'b0; bus_rdata_valid = 1'b0;
        tick(); tick();
        #1;
        chk("reset_flags", {31'h0, Inst_Req_Ack | Mem_Req_Ack | Inst_Valid | Read_data_Valid
                            | bus_wen | bus_ren | bus_rdata_ack}, 32'h0);
        chk("reset_addr", bus_addr, 32'h0);
        chk("reset_stall", stall_cnt, 32'h0);

        // fetch with minimum latency
        tick(); rst = 1'b0; PC = 32'h100; Inst_Req_Valid = 1'b1; #1;
        chk("fetch_c0_iack", {31'h0, Inst_Req_Ack}, 32'h1);
        chk("fetch_c0_mack", {31'h0, Mem_Req_Ack}, 32'h0);
        tick(); Inst_Req_Valid = 1'b0; bus_req_ack = 1'b1; #1;
        chk("fetch_c1_ren", {31'h0, bus_ren}, 32'h1);
        chk("fetch_c1_addr", bus_addr, 32'h100);
        chk("fetch_c1_wen", {31'h0, bus_wen}, 32'h0);
        tick(); bus_req_ack = 1'b0; bus_rdata = 32'h13; bus_rdata_valid = 1'b1; Inst_Ack = 1'b1; #1;
        chk("fetch_c2_ivalid", {31'h0, Inst_Valid}, 32'h1);
        chk("fetch_c2_instr", Instruction, 32'h13);
        chk("fetch_c2_rack", {31'h0, bus_rdata_ack}, 32'h1);
        chk("fetch_c2_ren", {31'h0, bus_ren}, 32'h0);
        tick(); bus_rdata_valid = 1'b0; Inst_Ack = 1'b0; Inst_Req_Valid = 1'b1; PC = 32'h104; #1;
        chk("fetch_c3_ivalid", {31'h0, Inst_Valid}, 32'h0);
        chk("fetch_c3_instr0", Instruction, 32'h0);
        chk("fetch_c3_regrant", {31'h0, Inst_Req_Ack}, 32'h1);

        // backpressure on the fetch response
        tick(); Inst_Req_Valid = 1'b0; bus_req_ack = 1'b1; #1;
        chk("bp_addr", bus_addr, 32'h104);
        for (int i = 0; i < 4; i++) begin
            tick(); bus_req_ack = 1'b0; bus_rdata_valid = 1'b1; bus_rdata = 32'h1000 + i; Inst_Ack = 1'b0; #1;
            chk("bp_instr", Instruction, 32'h1000 + i);
            chk("bp_ivalid", {31'h0, Inst_Valid}, 32'h1);
            chk("bp_rack", {31'h0, bus_rdata_ack}, 32'h0);
        end
        tick(); Inst_Ack = 1'b1; bus_rdata = 32'h2222; #1;
        chk("bp_release_rack", {31'h0, bus_rdata_ack}, 32'h1);
        chk("bp_release_instr", Instruction, 32'h2222);
        chk("bp_stall", stall_cnt, 32'h0);

        // store with a slow bus
        tick(); Inst_Ack = 1'b0; bus_rdata_valid = 1'b0;
        Address = 32'h200; MemWrite = 1'b1; Write_strb = 4'b0011; Write_data = 32'hABCD; #1;
        chk("st_ivalid_done", {31'h0, Inst_Valid}, 32'h0);
        chk("st_c0_mack", {31'h0, Mem_Req_Ack}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(); MemWrite = 1'b0; bus_req_ack = 1'b0; #1;
            chk("st_wen", {31'h0, bus_wen}, 32'h1);
            chk("st_ren", {31'h0, bus_ren}, 32'h0);
            chk("st_strb", {28'h0, bus_strb}, 32'h3);
            chk("st_wdata", bus_wdata, 32'hABCD);
            chk("st_addr", bus_addr, 32'h200);
        end
        tick(); bus_req_ack = 1'b1; #1;
        chk("st_ack_wen", {31'h0, bus_wen}, 32'h1);
        tick(); bus_req_ack = 1'b0; bus_rdata_valid = 1'b1; Read_data_Ack = 1'b1; #1;
        chk("st_idle_wen", {31'h0, bus_wen}, 32'h0);
        chk("st_no_rvalid", {31'h0, Read_data_Valid}, 32'h0);
        chk("st_idle_rack", {31'h0, bus_rdata_ack}, 32'h0);

        // tie with data priority, fetch waits two cycles
        tick(); bus_rdata_valid = 1'b0; Read_data_Ack = 1'b0;
        Inst_Req_Valid = 1'b1; PC = 32'h300; MemRead = 1'b1; Address = 32'h400; #1;
        chk("tie_mack", {31'h0, Mem_Req_Ack}, 32'h1);
        chk("tie_iack", {31'h0, Inst_Req_Ack}, 32'h0);
        tick(); MemRead = 1'b0; bus_req_ack = 1'b1; #1;
        chk("tie_c1_ren", {31'h0, bus_ren}, 32'h1);
        chk("tie_c1_addr", bus_addr, 32'h400);
        chk("tie_c1_iack", {31'h0, Inst_Req_Ack}, 32'h0);
        tick(); bus_req_ack = 1'b0; bus_rdata_valid = 1'b1; bus_rdata = 32'hDEAD_BEEF; Read_data_Ack = 1'b1; #1;
        chk("tie_c2_rvalid", {31'h0, Read_data_Valid}, 32'h1);
        chk("tie_c2_rdata", Read_data, 32'hDEAD_BEEF);
        chk("tie_c2_instr0", Instruction, 32'h0);
        chk("tie_c2_stall", stall_cnt, 32'h1);
        tick(); bus_rdata_valid = 1'b0; Read_data_Ack = 1'b0; #1;
        chk("tie_c3_iack", {31'h0, Inst_Req_Ack}, 32'h1);
        chk("tie_c3_stall", stall_cnt, 32'h2);
        tick(); Inst_Req_Valid = 1'b0; bus_req_ack = 1'b1; #1;
        chk("tie_c4_addr", bus_addr, 32'h300);
        chk("tie_c4_stall", stall_cnt, 32'h2);
        tick(); bus_req_ack = 1'b0; bus_rdata_valid = 1'b1; bus_rdata = 32'h55; Inst_Ack = 1'b1; #1;
        chk("tie_c5_instr", Instruction, 32'h55);

        // read and write together count as a write
        tick(); bus_rdata_valid = 1'b0; Inst_Ack = 1'b0; MemRead = 1'b1; MemWrite = 1'b1; Address = 32'h500; #1;
        chk("rw_mack", {31'h0, Mem_Req_Ack}, 32'h1);
        tick(); MemRead = 1'b0; MemWrite = 1'b0; bus_req_ack = 1'b1; #1;
        chk("rw_wen", {31'h0, bus_wen}, 32'h1);
        chk("rw_ren", {31'h0, bus_ren}, 32'h0);
        tick(); bus_req_ack = 1'b0; #1;
        chk("rw_idle_wen", {31'h0, bus_wen}, 32'h0);

        // reset while a read is in REQ_D
        MemRead = 1'b1; Address = 32'h600; #1;
        chk("rst_mack", {31'h0, Mem_Req_Ack}, 32'h1);
        tick(); MemRead = 1'b0; Inst_Req_Valid = 1'b1; #1;
        chk("rst_reqd_ren", {31'h0, bus_ren}, 32'h1);
        tick(); rst = 1'b1; Inst_Req_Valid = 1'b0; #1;
        chk("rst_pre_stall", stall_cnt, 32'h3);
        tick(); rst = 1'b0; bus_rdata_valid = 1'b1; bus_rdata = 32'h77; Read_data_Ack = 1'b1; #1;
        chk("rst_rvalid", {31'h0, Read_data_Valid}, 32'h0);
        chk("rst_rdata", Read_data, 32'h0);
        chk("rst_ren", {31'h0, bus_ren}, 32'h0);
        chk("rst_rack", {31'h0, bus_rdata_ack}, 32'h0);
        chk("rst_stall", stall_cnt, 32'h0);
        chk("rst_mack_idle", {31'h0, Mem_Req_Ack}, 32'h0);

        // round-robin vs data-first with both requesters always pending and a zero-wait bus
        tick(); rst = 1'b1; bus_rdata_valid = 1'b0; Read_data_Ack = 1'b0; #1;
        tick(); rst = 1'b0; Inst_Req_Valid = 1'b1; MemRead = 1'b1;
        bus_req_ack = 1'b1; bus_rdata_valid = 1'b1; Inst_Ack = 1'b1; Read_data_Ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            #1;
            chk("rr_mack", {31'h0, mem_req_ack_rr}, ((i % 6) == 0) ? 32'h1 : 32'h0);
            chk("rr_iack", {31'h0, inst_req_ack_rr}, ((i % 6) == 3) ? 32'h1 : 32'h0);
            chk("df_mack", {31'h0, Mem_Req_Ack}, ((i % 3) == 0) ? 32'h1 : 32'h0);
        end
        chk("df_iack_starved", {31'h0, Inst_Req_Ack}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/custom_mem_arbiter.md
CUSTOM_MEM_ARBITER -- requirements
Module: custom_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: DATA_FIRST, default 1, meaning data requests win simultaneous arbitration (0 = round-robin).
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- PC  in  32  instruction fetch address.
- Inst_Req_Valid  in  1  fetch request.
- Inst_Req_Ack  out  1  fetch request accepted.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  fetched word valid.
- Inst_Ack  in  1  CPU accepts fetched word.
- Address  in  32  data address, word-aligned.
- MemWrite  in  1  data write request.
- MemRead  in  1  data read request.
- Write_data  in  32  store data.
- Write_strb  in  4  byte enables.
- Mem_Req_Ack  out  1  data request accepted.
- Read_data  out  32  load data.
- Read_data_Valid  out  1  load data valid.
- Read_data_Ack  in  1  CPU accepts load data.
- bus_addr  out  32  shared-port address.
- bus_wen  out  1  shared-port write.
- bus_ren  out  1  shared-port read.
- bus_wdata  out  32  shared-port write data.
- bus_strb  out  4  shared-port byte enables.
- bus_req_ack  in  1  memory accepts request.
- bus_rdata  in  32  memory read data.
- bus_rdata_valid  in  1  memory read data valid.
- bus_rdata_ack  out  1  arbiter accepts read data.
- stall_cnt  out  32  cycles a requester waited without a grant.

Function
REQ-003 The block SHALL use states IDLE, REQ_I, REQ_D, RESP_I and RESP_D, with at most one transaction outstanding.
REQ-004 In IDLE, a pending requester SHALL be granted in that cycle.
- Inst pending = Inst_Req_Valid; data pending = MemRead|MemWrite.
- Grant asserts Inst_Req_Ack or Mem_Req_Ack for exactly that cycle.
- Grant latches addr, wdata, strb and kind (I / DR / DW) into internal registers.
- Next state: REQ_I (fetch) or REQ_D (data).
REQ-005 On simultaneous requests, DATA_FIRST=1 SHALL grant data; DATA_FIRST=0 SHALL grant the requester not granted last (last-grant flag resets to "inst", so data wins the first tie).
REQ-006 In REQ_I and REQ_D, bus_addr, bus_wdata and bus_strb SHALL be driven from the latched registers.
- bus_ren=1 for I and DR; bus_wen=1 for DW.
- Both are held until the cycle bus_req_ack=1.
REQ-007 On bus_req_ack, the next state SHALL be RESP_I for I, RESP_D for DR, and IDLE for DW (writes have no response phase).
REQ-008 In RESP_I, Instruction=bus_rdata, Inst_Valid=bus_rdata_valid and bus_rdata_ack=Inst_Ack (combinational); IDLE follows when bus_rdata_valid & Inst_Ack.
REQ-009 In RESP_D, Read_data=bus_rdata, Read_data_Valid=bus_rdata_valid and bus_rdata_ack=Read_data_Ack; IDLE follows when bus_rdata_valid & Read_data_Ack.
REQ-010 Outside their owning state, all bus request and response outputs SHALL be 0, and Instruction and Read_data SHALL be 0.
REQ-011 Minimum read latency SHALL be grant (cycle 0), bus request (cycle 1, acked same cycle), response (cycle 2, valid+ack), IDLE (cycle 3); a new grant is possible in cycle 3.
REQ-012 Requests arriving outside IDLE SHALL NOT be acked; the requester holds them, and they are granted on return to IDLE.
REQ-013 stall_cnt SHALL increment by 1 each cycle in which any request is pending but no upstream ack is given.
- Saturates at 32'hFFFF_FFFF.
- Both requesters pending and one granted SHALL count 0 for that cycle.
REQ-014 A MemRead and MemWrite both high SHALL be treated as a write.

Reset
REQ-015 While rst=1 at a clock edge, the block SHALL enter IDLE and clear the latched registers, the last-grant flag and stall_cnt; every output SHALL be 0 in the following cycle.
REQ-016 A reset mid-transaction (any non-IDLE state) SHALL abandon the transaction without any upstream valid or ack pulse; stale bus_rdata_valid after reset SHALL be ignored in IDLE.

Verification
REQ-017 Fetch: PC=0x100, Inst_Req_Valid=1, bus_req_ack=1, bus_rdata=0x00000013 valid one cycle later, Inst_Ack=1 -> Inst_Req_Ack in cycle 0, bus_ren/bus_addr=0x100 in cycle 1, Inst_Valid with Instruction=0x13 in cycle 2, IDLE in cycle 3.
REQ-018 Store: Address=0x200, MemWrite=1, Write_strb=4'b0011, Write_data=0xABCD -> Mem_Req_Ack in cycle 0; bus_wen=1, bus_strb=0011, bus_wdata=0xABCD held while bus_req_ack=0 for 3 cycles; IDLE the cycle after ack; no Read_data_Valid.
REQ-019 Tie: Inst_Req_Valid and MemRead both high in IDLE with DATA_FIRST=1 -> Mem_Req_Ack first; fetch granted after the read completes; stall_cnt equals the waiting cycles excluding the grant cycle.
REQ-020 Round-robin: DATA_FIRST=0, both requesters continuously pending -> grants alternate D, I, D, I.
REQ-021 Backpressure: bus_rdata_valid=1 and Inst_Ack=0 for 4 cycles -> state stays RESP_I, bus_rdata_ack=0, Instruction tracks bus_rdata.
REQ-022 Reset in REQ_D with a read pending -> IDLE next cycle, all outputs 0, stall_cnt=0, no Read_data_Valid.
